// File: rtl/enemy_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : enemy_spawn_scheduler
// Purpose  : Paces enemy spawns per level, caps live enemies, picks spawn points
//            round-robin and issues them over a valid/ready handshake.
//            Optional macro SPAWN_SPEEDUP_EN shortens the interval on later levels.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_spawn_scheduler #(
    parameter int SPAWN_INTERVAL = 25_000_000,
    parameter int MAX_ACTIVE     = 4,
    parameter int NUM_SPAWN_PTS  = 3,
    parameter int BASE_ENEMIES   = 6,
    parameter int LEVEL_STEP     = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     reset_game_i,
    input  logic                     is_playing_i,
    input  logic [3:0]               level_i,
    input  logic                     enemy_killed_i,
    input  logic [NUM_SPAWN_PTS-1:0] spawn_blocked_i,
    output logic                     spawn_valid_o,
    input  logic                     spawn_ready_i,
    output logic [1:0]               spawn_point_o,
    output logic [5:0]               enemy_left_o,
    output logic [3:0]               active_cnt_o
);

    localparam int c_timer_w = $clog2(SPAWN_INTERVAL + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PICK  = 3'd2,
        ST_OFFER = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_timer_w-1:0]   r_timer;
    logic [5:0]             r_to_spawn;
    logic [5:0]             r_enemy_left;
    logic [3:0]             r_active;
    logic [1:0]             r_rr_ptr;
    logic [1:0]             r_point;
    logic                   r_valid;

    logic [3:0]             w_level_eff;
    logic [11:0]            w_total_wide;
    logic [5:0]             w_total;
    logic [c_timer_w-1:0]   w_timer_max;
    logic                   w_timer_sat;
    logic                   w_kill;
    logic                   w_handshake;
    logic [3:0]             w_active_after_kill;
    logic [3:0]             w_blocked_pad;
    logic [2:0]             w_scan_idx;
    logic                   w_found;
    logic [1:0]             w_pick_pt;
    logic                   w_pick_go;

    // Level budget, level 0 behaves as level 1, clipped to the 6-bit counter range
    assign w_level_eff  = (level_i == 4'd0) ? 4'd1 : level_i;
    assign w_total_wide = 12'(BASE_ENEMIES) + 12'(LEVEL_STEP) * 12'(w_level_eff - 4'd1);
    assign w_total      = (w_total_wide > 12'd63) ? 6'd63 : w_total_wide[5:0];

`ifdef SPAWN_SPEEDUP_EN
    localparam int c_interval_half    = SPAWN_INTERVAL >> 1;
    localparam int c_interval_quarter = ((SPAWN_INTERVAL >> 2) < 1) ? 1 : (SPAWN_INTERVAL >> 2);

    always_comb begin
        if (w_level_eff >= 4'd8) begin
            w_timer_max = c_timer_w'(c_interval_quarter - 1);
        end else if (w_level_eff >= 4'd4) begin
            w_timer_max = c_timer_w'(c_interval_half - 1);
        end else begin
            w_timer_max = c_timer_w'(SPAWN_INTERVAL - 1);
        end
    end
`else
    assign w_timer_max = c_timer_w'(SPAWN_INTERVAL - 1);
`endif

    // >= so a level change that shrinks the interval never strands the timer above it
    assign w_timer_sat         = (r_timer >= w_timer_max);
    assign w_kill              = enemy_killed_i && (r_active != 4'd0);
    assign w_handshake         = r_valid && spawn_ready_i;
    assign w_active_after_kill = r_active - {3'b000, w_kill};

    // Round-robin scan starting at r_rr_ptr; pad bits beyond the real points read as blocked
    always_comb begin
        w_blocked_pad = 4'b1111;
        for (int i = 0; i < NUM_SPAWN_PTS; i++) begin
            w_blocked_pad[i] = spawn_blocked_i[i];
        end
        w_found    = 1'b0;
        w_pick_pt  = 2'd0;
        w_scan_idx = 3'd0;
        for (int i = 0; i < NUM_SPAWN_PTS; i++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + 3'(i);
            if (w_scan_idx >= 3'(NUM_SPAWN_PTS)) begin
                w_scan_idx = w_scan_idx - 3'(NUM_SPAWN_PTS);
            end
            if (!w_found && !w_blocked_pad[w_scan_idx[1:0]]) begin
                w_found   = 1'b1;
                w_pick_pt = w_scan_idx[1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pick_go   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (is_playing_i && (r_to_spawn != 6'd0)) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_timer_sat && (r_to_spawn != 6'd0) &&
                    (w_active_after_kill < 4'(MAX_ACTIVE))) begin
                    w_state_nxt = ST_PICK;
                end
            end
            ST_PICK: begin
                if (is_playing_i && w_found) begin
                    w_state_nxt = ST_OFFER;
                    w_pick_go   = 1'b1;
                end
            end
            ST_OFFER: begin
                if (w_handshake) begin
                    w_state_nxt = (r_to_spawn == 6'd1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (reset_game_i) begin
            w_state_nxt = ST_IDLE;
            w_pick_go   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_timer      <= '0;
            r_to_spawn   <= 6'd0;
            r_enemy_left <= 6'd0;
            r_active     <= 4'd0;
            r_rr_ptr     <= 2'd0;
            r_point      <= 2'd0;
            r_valid      <= 1'b0;
        end else if (reset_game_i) begin
            r_timer      <= '0;
            r_to_spawn   <= w_total;
            r_enemy_left <= w_total;
            r_active     <= 4'd0;
            r_rr_ptr     <= 2'd0;
            r_valid      <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_timer <= '0;
            end else if ((r_state == ST_WAIT) && is_playing_i && !w_timer_sat) begin
                r_timer <= r_timer + c_timer_w'(1);
            end

            if (w_pick_go) begin
                r_valid <= 1'b1;
                r_point <= w_pick_pt;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end

            // A kill landing on the accept cycle cancels the active increment
            if (w_handshake) begin
                r_to_spawn <= r_to_spawn - 6'd1;
                r_rr_ptr   <= (r_point == 2'(NUM_SPAWN_PTS - 1)) ? 2'd0 : r_point + 2'd1;
                if (w_kill) begin
                    r_enemy_left <= r_enemy_left - 6'd1;
                end else begin
                    r_active <= r_active + 4'd1;
                end
            end else if (w_kill) begin
                r_active     <= r_active - 4'd1;
                r_enemy_left <= r_enemy_left - 6'd1;
            end
        end
    end

    assign spawn_valid_o = r_valid;
    assign spawn_point_o = r_point;
    assign enemy_left_o  = r_enemy_left;
    assign active_cnt_o  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_enemy_spawn_scheduler.sv
`default_nettype none
// Testbench for enemy_spawn_scheduler: budget table, directed corner sequences
// and randomized traffic compared against a counting reference model.
module tb_enemy_spawn_scheduler;

    localparam int P_INTERVAL = 8;
    localparam int P_MAX      = 2;
    localparam int P_PTS      = 3;
    localparam int P_BASE     = 6;
    localparam int P_STEP     = 2;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       reset_game_i;
    logic       is_playing_i;
    logic [3:0] level_i;
    logic       enemy_killed_i;
    logic [2:0] spawn_blocked_i;
    logic       spawn_valid_o;
    logic       spawn_ready_i;
    logic [1:0] spawn_point_o;
    logic [5:0] enemy_left_o;
    logic [3:0] active_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    enemy_spawn_scheduler #(
        .SPAWN_INTERVAL (P_INTERVAL),
        .MAX_ACTIVE     (P_MAX),
        .NUM_SPAWN_PTS  (P_PTS),
        .BASE_ENEMIES   (P_BASE),
        .LEVEL_STEP     (P_STEP)
    ) dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .reset_game_i    (reset_game_i),
        .is_playing_i    (is_playing_i),
        .level_i         (level_i),
        .enemy_killed_i  (enemy_killed_i),
        .spawn_blocked_i (spawn_blocked_i),
        .spawn_valid_o   (spawn_valid_o),
        .spawn_ready_i   (spawn_ready_i),
        .spawn_point_o   (spawn_point_o),
        .enemy_left_o    (enemy_left_o),
        .active_cnt_o    (active_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: counters plus "started / picking / offering" flags
    int m_left, m_tospawn, m_active, m_rr, m_elapsed, m_point;
    bit m_started, m_picking, m_valid;

    function automatic int budget(input int lvl);
        int l;
        int t;
        l = (lvl < 1) ? 1 : lvl;
        t = P_BASE + P_STEP * (l - 1);
        return (t > 63) ? 63 : t;
    endfunction

    function automatic int eff_interval(input int lvl);
        int iv;
        iv = P_INTERVAL;
`ifdef SPAWN_SPEEDUP_EN
        if (lvl >= 8) iv = ((P_INTERVAL / 4) < 1) ? 1 : P_INTERVAL / 4;
        else if (lvl >= 4) iv = P_INTERVAL / 2;
`endif
        return iv;
    endfunction

    function automatic void model_clock();
        int  kill, hs, lvl, p;
        int  n_left, n_tospawn, n_active, n_rr, n_elapsed, n_point;
        bit  n_started, n_picking, n_valid, in_wait, found;
        lvl = (int'(level_i) == 0) ? 1 : int'(level_i);
        if (reset_game_i) begin
            m_left    = budget(lvl);
            m_tospawn = m_left;
            m_active  = 0;
            m_rr      = 0;
            m_elapsed = 0;
            m_started = 1'b0;
            m_picking = 1'b0;
            m_valid   = 1'b0;
            return;
        end
        kill = (enemy_killed_i && m_active > 0) ? 1 : 0;
        hs   = (m_valid && spawn_ready_i) ? 1 : 0;
        n_left = m_left - kill;
        n_tospawn = m_tospawn;
        n_active = m_active + hs - kill;
        n_rr = m_rr;
        n_elapsed = m_elapsed;
        n_point = m_point;
        n_started = m_started;
        n_picking = m_picking;
        n_valid = m_valid;
        in_wait = m_started && !m_picking && !m_valid && (m_tospawn > 0);
        if (!m_started && is_playing_i && m_tospawn > 0) n_started = 1'b1;
        if (in_wait) begin
            if (m_elapsed >= eff_interval(lvl) - 1) begin
                if (m_active - kill < P_MAX) n_picking = 1'b1;
            end else if (is_playing_i) begin
                n_elapsed = m_elapsed + 1;
            end
        end
        if (m_picking && is_playing_i) begin
            found = 1'b0;
            for (int k = 0; k < P_PTS; k++) begin
                p = (m_rr + k) % P_PTS;
                if (!found && !spawn_blocked_i[p]) begin
                    found = 1'b1;
                    n_point = p;
                end
            end
            if (found) begin
                n_picking = 1'b0;
                n_valid = 1'b1;
            end
        end
        if (hs == 1) begin
            n_valid = 1'b0;
            n_tospawn = m_tospawn - 1;
            n_elapsed = 0;
            n_rr = (m_point + 1) % P_PTS;
        end
        m_left = n_left; m_tospawn = n_tospawn; m_active = n_active; m_rr = n_rr;
        m_elapsed = n_elapsed; m_point = n_point; m_started = n_started;
        m_picking = n_picking; m_valid = n_valid;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_left", int'(enemy_left_o), m_left);
        check("model_active", int'(active_cnt_o), m_active);
        check("model_valid", int'(spawn_valid_o), int'(m_valid));
        if (m_valid) check("model_point", int'(spawn_point_o), m_point);
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_model();
    endtask

    task automatic run_until_valid(input int max_cycles, output int n);
        n = 0;
        while (!spawn_valid_o && n < max_cycles) begin
            tick();
            n++;
        end
        if (!spawn_valid_o) check("valid_timeout", 0, 1);
    endtask

    task automatic game_reload(input logic [3:0] lvl);
        level_i = lvl;
        reset_game_i = 1'b1;
        tick();
        reset_game_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0] level;
        int         exp_left;
    } budget_vec_t;

    budget_vec_t vecs[6];

    initial begin
        int n;
        int seen;

        vecs[0] = '{4'd0, 6};
        vecs[1] = '{4'd1, 6};
        vecs[2] = '{4'd2, 8};
        vecs[3] = '{4'd3, 10};
        vecs[4] = '{4'd7, 18};
        vecs[5] = '{4'd15, 34};

        reset_ni = 1'b0;
        reset_game_i = 1'b0;
        is_playing_i = 1'b0;
        level_i = 4'd1;
        enemy_killed_i = 1'b0;
        spawn_blocked_i = 3'b000;
        spawn_ready_i = 1'b0;
        m_left = 0; m_tospawn = 0; m_active = 0; m_rr = 0; m_elapsed = 0; m_point = 0;
        m_started = 1'b0; m_picking = 1'b0; m_valid = 1'b0;

        repeat (3) @(negedge clk_i);
        check("reset_valid", int'(spawn_valid_o), 0);
        check("reset_point", int'(spawn_point_o), 0);
        check("reset_left", int'(enemy_left_o), 0);
        check("reset_active", int'(active_cnt_o), 0);
        reset_ni = 1'b1;
        is_playing_i = 1'b1;
        tick();
        check("idle_no_budget_valid", int'(spawn_valid_o), 0);
        is_playing_i = 1'b0;

        // Budget table
        for (int i = 0; i < 6; i++) begin
            game_reload(vecs[i].level);
            check("budget_left", int'(enemy_left_o), vecs[i].exp_left);
            check("budget_active", int'(active_cnt_o), 0);
            check("budget_valid", int'(spawn_valid_o), 0);
        end

        // First spawn latency, pacing and the active cap
        game_reload(4'd3);
        check("lvl3_left", int'(enemy_left_o), 10);
        is_playing_i = 1'b1;
        run_until_valid(40, n);
        check("first_valid_latency", n, 10);
        check("first_point", int'(spawn_point_o), 0);
        spawn_ready_i = 1'b1;
        tick();
        run_until_valid(40, n);
        check("second_valid_latency", n, 9);
        check("second_point", int'(spawn_point_o), 1);
        tick();
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (spawn_valid_o) seen++;
        end
        check("cap_no_valid", seen, 0);
        check("cap_active", int'(active_cnt_o), 2);
        enemy_killed_i = 1'b1;
        tick();
        enemy_killed_i = 1'b0;
        check("kill_left", int'(enemy_left_o), 9);
        check("kill_active", int'(active_cnt_o), 1);
        run_until_valid(10, n);
        check("kill_reenable_latency", n, 1);
        check("third_point", int'(spawn_point_o), 2);

        // Blocked points
        spawn_ready_i = 1'b0;
        spawn_blocked_i = 3'b011;
        game_reload(4'd3);
        run_until_valid(40, n);
        check("blocked_011_point", int'(spawn_point_o), 2);
        spawn_ready_i = 1'b1;
        tick();
        spawn_blocked_i = 3'b111;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (spawn_valid_o) seen++;
        end
        check("all_blocked_no_valid", seen, 0);
        spawn_ready_i = 1'b0;
        spawn_blocked_i = 3'b101;
        run_until_valid(5, n);
        check("unblock_latency", n, 1);
        check("unblock_point", int'(spawn_point_o), 1);

        // Offer held under back-pressure, pause and blocked changes
        is_playing_i = 1'b0;
        spawn_blocked_i = 3'b010;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (spawn_valid_o && spawn_point_o == 2'd1) seen++;
        end
        check("offer_held", seen, 5);
        spawn_ready_i = 1'b1;
        enemy_killed_i = 1'b1;
        tick();
        spawn_ready_i = 1'b0;
        enemy_killed_i = 1'b0;
        check("accept_kill_active", int'(active_cnt_o), 1);
        check("accept_kill_left", int'(enemy_left_o), 9);
        check("accept_valid_drop", int'(spawn_valid_o), 0);

        // Level 15, kill with nothing alive, reload mid-offer
        spawn_blocked_i = 3'b000;
        game_reload(4'd15);
        check("lvl15_left", int'(enemy_left_o), 34);
        enemy_killed_i = 1'b1;
        tick();
        enemy_killed_i = 1'b0;
        check("kill_underflow_left", int'(enemy_left_o), 34);
        check("kill_underflow_active", int'(active_cnt_o), 0);
        is_playing_i = 1'b1;
        run_until_valid(40, n);
        spawn_ready_i = 1'b1;
        tick();
        spawn_ready_i = 1'b0;
        check("lvl15_active1", int'(active_cnt_o), 1);
        run_until_valid(40, n);
        game_reload(4'd15);
        check("reload_valid", int'(spawn_valid_o), 0);
        check("reload_left", int'(enemy_left_o), 34);
        check("reload_active", int'(active_cnt_o), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset_game_i = ($urandom_range(0, 199) == 0);
            if (reset_game_i) level_i = 4'($urandom_range(0, 15));
            is_playing_i = ($urandom_range(0, 9) != 0);
            enemy_killed_i = ($urandom_range(0, 3) == 0);
            spawn_ready_i = ($urandom_range(0, 1) == 1);
            spawn_blocked_i = 3'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
